// File: rtl/kws_mem_pkg.sv
// Shared helpers for the KWS window memory: frame sizing, modular index
// arithmetic and a zero-frame constant.
package kws_mem_pkg;

    // Upper bound on a single frame's width; ZERO_FRAME is sliced to W bits.
    localparam int unsigned MAX_FRAME_W = 4096;

    localparam logic [MAX_FRAME_W-1:0] ZERO_FRAME = '0;

    // Width of one frame: C channels of N bits each.
    function automatic int unsigned frame_width(input int unsigned c, input int unsigned n);
        return c * n;
    endfunction

    // (a + b) mod m for a < m and b < m, using one compare-and-subtract.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned m);
        int unsigned s;
        s = a + b;
        if (s >= m) begin
            s = s - m;
        end
        return s;
    endfunction

endpackage

// File: rtl/window_memory_wrap_counter.sv
// Modulo-M up counter with synchronous clear; used as the window write pointer.
module wrap_counter #(
    parameter int unsigned M = 5,
    localparam int unsigned AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] value
);

    localparam logic [AW-1:0] LAST = AW'(M - 1);

    // Advance on inc, wrapping from M-1 back to 0; clr takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + AW'(1);
        end
    end

endmodule

// File: rtl/window_memory.sv
// Circular frame buffer holding the last M feature frames. Presents the full
// window oldest-first and a registered random read by logical age index.
module window_memory
    import kws_mem_pkg::*;
#(
    parameter int unsigned M = 5,
    parameter int unsigned N = 8,
    parameter int unsigned C = 1,
    localparam int unsigned AW = $clog2(M),
    localparam int unsigned CW = $clog2(M + 1),
    localparam int unsigned W  = frame_width(C, N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [C*N-1:0]   data_in,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             freeze,
    input  logic             clear,
    input  logic [AW-1:0]    rd_addr,
    output logic [C*N-1:0]   data_out,
    output logic [M*C*N-1:0] all_data_out,
    output logic [CW-1:0]    count,
    output logic             window_full,
    output logic             new_frame
);

    localparam logic [CW-1:0] M_CNT = CW'(M);

    logic [W-1:0]  mem [M];
    logic [AW-1:0] wp;
    logic [AW-1:0] base;
    logic [AW-1:0] rd_phys;
    logic          rd_in_range;
    logic          wr_en;

    // Physical slot of logical index i given the oldest-frame base.
    function automatic logic [AW-1:0] phys(input logic [AW-1:0] b, input int unsigned i);
        return AW'(wrap_add(32'(b), i, M));
    endfunction

    assign wr_ready    = !freeze && !clear;
    assign wr_en       = wr_valid && wr_ready;
    assign window_full = (count == M_CNT);
    // Until the window fills, slot 0 holds the oldest frame; afterwards the
    // write pointer sits on the oldest frame.
    assign base        = window_full ? wp : '0;
    assign rd_in_range = (32'(rd_addr) < M);
    assign rd_phys     = rd_in_range ? phys(base, 32'(rd_addr)) : '0;

    wrap_counter #(.M(M)) u_wp (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (wr_en),
        .value (wp)
    );

    // Frame storage: zeroed on reset/clear, written at the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < M; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < M; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wp] <= data_in;
        end
    end

    // Occupancy (saturating at M) and the window-updated pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            new_frame <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            new_frame <= 1'b0;
        end else begin
            new_frame <= wr_en && ((count == M_CNT) || (count == M_CNT - CW'(1)));
            if (wr_en && (count != M_CNT)) begin
                count <= count + CW'(1);
            end
        end
    end

    // Registered read by logical age; sees pre-write contents on a shared edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (clear) begin
            data_out <= '0;
        end else begin
            data_out <= rd_in_range ? mem[rd_phys] : ZERO_FRAME[W-1:0];
        end
    end

    // Flatten the window oldest-first.
    always_comb begin
        all_data_out = '0;
        for (int unsigned i = 0; i < M; i++) begin
            all_data_out[i*W +: W] = mem[phys(base, i)];
        end
    end

endmodule
